// File: rtl/fft4_stream.sv
// Streaming 4-point radix-2 forward FFT: load 4 samples, two registered
// butterfly stages, then unload 4 unscaled bins with valid/ready.
module fft4_stream #(
    parameter int DW = 16,
    parameter int OW = DW + 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] x_real,
    input  logic signed [DW-1:0] x_imag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [OW-1:0] y_real,
    output logic signed [OW-1:0] y_imag,
    output logic [1:0]           y_index,
    output logic                 y_last
);

    typedef enum logic [1:0] {LOAD, BF1, BF2, OUT} state_t;

    state_t state, state_nx;

    logic [1:0] cnt;
    logic [1:0] idx;
    logic take;
    logic give;

    logic signed [DW-1:0] xr [4];
    logic signed [DW-1:0] xi [4];
    logic signed [DW:0]   ar, ai, br, bi, cr, ci, dr, di;
    logic signed [OW-1:0] yr [4];
    logic signed [OW-1:0] yi [4];

    function automatic logic signed [DW:0] sx1(input logic signed [DW-1:0] v);
        return {v[DW-1], v};
    endfunction

    function automatic logic signed [OW-1:0] sx2(input logic signed [DW:0] v);
        return {v[DW], v};
    endfunction

    assign in_ready  = (state == LOAD);
    assign out_valid = (state == OUT);
    assign take      = in_valid && in_ready;
    assign give      = out_valid && out_ready;

    // Bins are held in registers, so the mux output is stable under stall.
    assign y_real  = out_valid ? yr[idx] : '0;
    assign y_imag  = out_valid ? yi[idx] : '0;
    assign y_index = out_valid ? idx : 2'd0;
    assign y_last  = out_valid && (idx == 2'd3);

    always_comb begin
        state_nx = state;
        unique case (state)
            LOAD: if (take && cnt == 2'd3) state_nx = BF1;
            BF1:  state_nx = BF2;
            BF2:  state_nx = OUT;
            OUT:  if (give && idx == 2'd3) state_nx = LOAD;
            default: state_nx = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LOAD;
            cnt   <= 2'd0;
            idx   <= 2'd0;
            ar <= '0; ai <= '0; br <= '0; bi <= '0;
            cr <= '0; ci <= '0; dr <= '0; di <= '0;
            for (int n = 0; n < 4; n++) begin
                xr[n] <= '0;
                xi[n] <= '0;
                yr[n] <= '0;
                yi[n] <= '0;
            end
        end else begin
            state <= state_nx;
            if (take) begin
                xr[cnt] <= x_real;
                xi[cnt] <= x_imag;
                cnt     <= cnt + 2'd1;
            end
            if (state == BF1) begin
                ar <= sx1(xr[0]) + sx1(xr[2]);
                ai <= sx1(xi[0]) + sx1(xi[2]);
                br <= sx1(xr[0]) - sx1(xr[2]);
                bi <= sx1(xi[0]) - sx1(xi[2]);
                cr <= sx1(xr[1]) + sx1(xr[3]);
                ci <= sx1(xi[1]) + sx1(xi[3]);
                dr <= sx1(xr[1]) - sx1(xr[3]);
                di <= sx1(xi[1]) - sx1(xi[3]);
            end
            if (state == BF2) begin
                // X1 = b - j*d, X3 = b + j*d
                yr[0] <= sx2(ar) + sx2(cr);
                yi[0] <= sx2(ai) + sx2(ci);
                yr[2] <= sx2(ar) - sx2(cr);
                yi[2] <= sx2(ai) - sx2(ci);
                yr[1] <= sx2(br) + sx2(di);
                yi[1] <= sx2(bi) - sx2(dr);
                yr[3] <= sx2(br) - sx2(di);
                yi[3] <= sx2(bi) + sx2(dr);
                idx   <= 2'd0;
            end
            if (give) idx <= idx + 2'd1;
        end
    end

endmodule

// File: tb/tb_fft4_stream.sv
// Bench for fft4_stream: directed and random frames against a DFT
// reference computed directly from the twiddle definition.
module tb_fft4_stream;

    localparam int DW = 16;
    localparam int OW = DW + 2;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] x_real;
    logic signed [DW-1:0] x_imag;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [OW-1:0] y_real;
    logic signed [OW-1:0] y_imag;
    logic [1:0]           y_index;
    logic                 y_last;

    int checks   = 0;
    int failures = 0;

    int sr [4];
    int si [4];
    longint er [4];
    longint ei [4];

    fft4_stream #(.DW(DW), .OW(OW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_real    (x_real),
        .x_imag    (x_imag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y_real    (y_real),
        .y_imag    (y_imag),
        .y_index   (y_index),
        .y_last    (y_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // X[k] = sum_n x[n] * (-j)^(n*k), rotating by -j m times.
    task automatic model();
        for (int k = 0; k < 4; k++) begin
            longint acr = 0;
            longint aci = 0;
            for (int n = 0; n < 4; n++) begin
                longint r = sr[n];
                longint i = si[n];
                longint t;
                for (int m = 0; m < (n * k) % 4; m++) begin
                    t = r;
                    r = i;
                    i = -t;
                end
                acr += r;
                aci += i;
            end
            er[k] = acr;
            ei[k] = aci;
        end
    endtask

    task automatic set_frame(input int r0, input int i0, input int r1, input int i1,
                             input int r2, input int i2, input int r3, input int i3);
        sr[0] = r0; si[0] = i0; sr[1] = r1; si[1] = i1;
        sr[2] = r2; si[2] = i2; sr[3] = r3; si[3] = i3;
    endtask

    task automatic rand_frame();
        logic signed [DW-1:0] v;
        for (int n = 0; n < 4; n++) begin
            v = DW'($urandom);
            sr[n] = int'(v);
            v = DW'($urandom);
            si[n] = int'(v);
        end
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        reset     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Feed samples 0..nsamp-1 of sr/si; returns at the negedge after the last accept.
    task automatic load_frame(input int nsamp, input int gap_max, input bit keep);
        for (int n = 0; n < nsamp; n++) begin
            int g;
            int t;
            g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            in_valid = 1'b0;
            for (int q = 0; q < g; q++) begin
                x_real = DW'($urandom);
                x_imag = DW'($urandom);
                @(negedge clk);
            end
            in_valid = 1'b1;
            x_real = DW'(sr[n]);
            x_imag = DW'(si[n]);
            t = 0;
            while (!in_ready && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (!in_ready) begin
                check("load_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            @(negedge clk);
        end
        if (keep) begin
            x_real = DW'($urandom);
            x_imag = DW'($urandom);
        end else begin
            in_valid = 1'b0;
        end
    endtask

    // Unload bins; stall bin 0 for first_stall cycles, others randomly.
    // Stops before handshaking bin stop_at (4 = full frame).
    task automatic recv_frame(input int first_stall, input int stall_max, input int stop_at);
        model();
        for (int k = 0; k < 4; k++) begin
            int t;
            int s;
            t = 0;
            out_ready = 1'b0;
            while (!out_valid && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (!out_valid) begin
                check("out_timeout", 0, 1);
                return;
            end
            check($sformatf("bin%0d_in_ready", k), longint'(in_ready), 0);
            check($sformatf("bin%0d_real", k), longint'(y_real), er[k]);
            check($sformatf("bin%0d_imag", k), longint'(y_imag), ei[k]);
            check($sformatf("bin%0d_index", k), longint'(y_index), longint'(k));
            check($sformatf("bin%0d_last", k), longint'(y_last), (k == 3) ? 1 : 0);
            if (k == stop_at) return;
            s = (k == 0) ? first_stall :
                (stall_max > 0 ? int'($urandom_range(stall_max, 0)) : 0);
            for (int q = 0; q < s; q++) begin
                @(negedge clk);
                check($sformatf("stall%0d_valid", k), longint'(out_valid), 1);
                check($sformatf("stall%0d_real", k), longint'(y_real), er[k]);
                check($sformatf("stall%0d_imag", k), longint'(y_imag), ei[k]);
                check($sformatf("stall%0d_in_ready", k), longint'(in_ready), 0);
            end
            out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            out_ready = 1'b0;
        end
        check("done_valid", longint'(out_valid), 0);
        check("done_in_ready", longint'(in_ready), 1);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x_real    = '0;
        x_imag    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", longint'(in_ready), 1);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_y_real", longint'(y_real), 0);
        check("rst_y_imag", longint'(y_imag), 0);
        check("rst_y_index", longint'(y_index), 0);
        check("rst_y_last", longint'(y_last), 0);
        reset = 1'b0;

        // Impulse with latency check
        set_frame(1, 0, 0, 0, 0, 0, 0, 0);
        load_frame(4, 0, 1'b0);
        check("lat_bf1_valid", longint'(out_valid), 0);
        check("lat_bf1_in_ready", longint'(in_ready), 0);
        @(negedge clk);
        check("lat_bf2_valid", longint'(out_valid), 0);
        @(negedge clk);
        check("lat_out_valid", longint'(out_valid), 1);
        recv_frame(0, 0, 4);

        // Shifted impulse
        set_frame(0, 0, 1, 0, 0, 0, 0, 0);
        load_frame(4, 0, 1'b0);
        recv_frame(0, 0, 4);

        // Extreme DC, both signs
        set_frame(-32768, 0, -32768, 0, -32768, 0, -32768, 0);
        load_frame(4, 0, 1'b0);
        recv_frame(0, 0, 4);
        set_frame(32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767);
        load_frame(4, 0, 1'b0);
        recv_frame(0, 0, 4);

        // Backpressure on bin 0
        set_frame(1, 0, 2, 0, 3, 0, 4, 0);
        load_frame(4, 0, 1'b0);
        recv_frame(5, 2, 4);

        // Sparse input, in_valid held high while busy
        rand_frame();
        load_frame(4, 3, 1'b1);
        recv_frame(1, 2, 4);
        in_valid = 1'b0;
        rand_frame();
        load_frame(4, 0, 1'b0);
        recv_frame(0, 0, 4);

        // Reset mid-load discards the partial frame
        rand_frame();
        load_frame(2, 0, 1'b0);
        do_reset();
        check("rstload_in_ready", longint'(in_ready), 1);
        check("rstload_out_valid", longint'(out_valid), 0);
        set_frame(1, 0, 1, 0, 1, 0, 1, 0);
        load_frame(4, 0, 1'b0);
        recv_frame(0, 0, 4);

        // Reset during unload at bin 1
        rand_frame();
        load_frame(4, 0, 1'b0);
        recv_frame(0, 0, 1);
        do_reset();
        check("rstout_out_valid", longint'(out_valid), 0);
        check("rstout_in_ready", longint'(in_ready), 1);
        check("rstout_y_real", longint'(y_real), 0);
        rand_frame();
        load_frame(4, 1, 1'b0);
        recv_frame(0, 1, 4);

        // Random frames
        for (int f = 0; f < 10; f++) begin
            rand_frame();
            load_frame(4, 2, f[0]);
            recv_frame(int'($urandom_range(3, 0)), 3, 4);
            in_valid = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
